// File: rtl/bsg_axil_to_fifos_rx.sv
// AXI-Lite read-channel slave exposing the receive side of num_fifos_p FIFOs
// as memory-mapped RDR (pop), RDFO (occupancy) and ISR (sticky receive-complete) registers.
module bsg_axil_to_fifos_rx #(
   parameter int                           num_fifos_p       = 1,
   parameter int                           occ_width_p       = 16,
   parameter int                           base_addr_width_p = 8,
   parameter logic [31:0]                  axil_base_addr_p  = 32'h0,
   parameter logic [base_addr_width_p-1:0] ofs_rdr_lp        = 'h20,
   parameter logic [base_addr_width_p-1:0] ofs_rdfo_lp       = 'h1C,
   parameter logic [base_addr_width_p-1:0] ofs_isr_lp        = 'h00,
   parameter int                           FIFO_ISR_RC_BIT_p = 26
) (
   input  logic                                   clk_i,
   input  logic                                   reset_ni,
   input  logic [31:0]                            araddr_i,
   input  logic                                   arvalid_i,
   output logic                                   arready_o,
   output logic [31:0]                            rdata_o,
   output logic [1:0]                             rresp_o,
   output logic                                   rvalid_o,
   input  logic                                   rready_i,
   input  logic [num_fifos_p-1:0][31:0]           rx_data_i,
   input  logic [num_fifos_p-1:0]                 rx_v_i,
   output logic [num_fifos_p-1:0]                 rx_ready_o,
   input  logic [num_fifos_p-1:0][occ_width_p-1:0] rx_occ_i,
   input  logic [num_fifos_p-1:0]                 clear_isr_rc_i,
   output logic [num_fifos_p-1:0]                 isr_rc_o
);

   localparam int          index_addr_width_lp = 32 - base_addr_width_p;
   localparam logic [31:0] base_index_lp       = axil_base_addr_p >> base_addr_width_p;

   typedef enum logic [1:0] {
      E_RD_IDLE = 2'd0,
      E_RD_ADDR = 2'd1,
      E_RD_DATA = 2'd2,
      E_RD_RESP = 2'd3
   } rd_state_e;

   rd_state_e                state_r, state_n;
   logic [31:0]              addr_r;
   logic [31:0]              rdata_r, rdata_n;
   logic [1:0]               rresp_r, rresp_n;
   logic [num_fifos_p-1:0]   pop_n;
   logic [num_fifos_p-1:0]   rx_v_r;
   logic [num_fifos_p-1:0]   isr_rc_r;
   logic [base_addr_width_p-1:0] ofs;

   // Handshake: address accepted on the single E_RD_ADDR cycle (arready_o=1);
   // response held with rvalid_o=1 and stable rdata/rresp until rready_i=1.
   assign arready_o  = (state_r == E_RD_ADDR);
   assign rvalid_o   = (state_r == E_RD_RESP);
   assign rdata_o    = rdata_r;
   assign rresp_o    = rresp_r;
   assign isr_rc_o   = isr_rc_r;
   assign rx_ready_o = (state_r == E_RD_DATA) ? pop_n : '0;
   assign ofs        = addr_r[0 +: base_addr_width_p];

   always_comb begin
      state_n = state_r;
      case (state_r)
         E_RD_IDLE: if (arvalid_i) state_n = E_RD_ADDR;
         E_RD_ADDR: state_n = E_RD_DATA;
         E_RD_DATA: state_n = E_RD_RESP;
         E_RD_RESP: if (rready_i) state_n = E_RD_IDLE;
         default:   state_n = E_RD_IDLE;
      endcase
   end

   // Index hits are mutually exclusive, so at most one FIFO can be popped.
   always_comb begin
      rdata_n = '0;
      rresp_n = 2'b11;
      pop_n   = '0;
      for (int i = 0; i < num_fifos_p; i++) begin
         if (addr_r[base_addr_width_p +: index_addr_width_lp] ==
             index_addr_width_lp'(base_index_lp + 32'(i))) begin
            rresp_n = 2'b00;
            if (ofs == ofs_rdr_lp) begin
               if (rx_v_i[i]) begin
                  rdata_n  = rx_data_i[i];
                  pop_n[i] = 1'b1;
               end else begin
                  rresp_n = 2'b10;
               end
            end else if (ofs == ofs_rdfo_lp) begin
               rdata_n = 32'(rx_occ_i[i]);
            end else if (ofs == ofs_isr_lp) begin
               rdata_n[FIFO_ISR_RC_BIT_p] = isr_rc_r[i];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_r <= E_RD_IDLE;
         addr_r  <= '0;
         rdata_r <= '0;
         rresp_r <= 2'b00;
      end else begin
         state_r <= state_n;
         if (state_r == E_RD_ADDR) addr_r <= araddr_i;
         if (state_r == E_RD_DATA) begin
            rdata_r <= rdata_n;
            rresp_r <= rresp_n;
         end
      end
   end

   // Receive-complete: set on a rising rx_v_i edge; a coincident clear loses.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rx_v_r   <= '0;
         isr_rc_r <= '0;
      end else begin
         rx_v_r   <= rx_v_i;
         isr_rc_r <= (isr_rc_r & ~clear_isr_rc_i) | (rx_v_i & ~rx_v_r);
      end
   end

endmodule

// File: tb/tb_bsg_axil_to_fifos_rx.sv
// Directed bench for bsg_axil_to_fifos_rx with two FIFOs, base width 8, base address 0.
module tb_bsg_axil_to_fifos_rx;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [31:0]       araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;
   logic [1:0][31:0]  rx_data;
   logic [1:0]        rx_v;
   logic [1:0]        rx_ready;
   logic [1:0][15:0]  rx_occ;
   logic [1:0]        clear_isr;
   logic [1:0]        isr_rc;

   int n_cmp = 0;
   int n_err = 0;
   int pop_cnt = 0;
   int pop_base;

   bsg_axil_to_fifos_rx #(
      .num_fifos_p(2),
      .occ_width_p(16),
      .base_addr_width_p(8),
      .axil_base_addr_p(32'h0),
      .ofs_rdr_lp(8'h20),
      .ofs_rdfo_lp(8'h1C),
      .ofs_isr_lp(8'h00),
      .FIFO_ISR_RC_BIT_p(26)
   ) dut (
      .clk_i(clk),
      .reset_ni(reset_n),
      .araddr_i(araddr),
      .arvalid_i(arvalid),
      .arready_o(arready),
      .rdata_o(rdata),
      .rresp_o(rresp),
      .rvalid_o(rvalid),
      .rready_i(rready),
      .rx_data_i(rx_data),
      .rx_v_i(rx_v),
      .rx_ready_o(rx_ready),
      .rx_occ_i(rx_occ),
      .clear_isr_rc_i(clear_isr),
      .isr_rc_o(isr_rc)
   );

   // clock / reset
   always #5 clk = ~clk;

   // pop counter sampled mid-cycle, where rx_ready_o is settled
   always @(negedge clk) pop_cnt = pop_cnt + $countones(rx_ready);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full read; rready is held low for n_wait extra cycles while inputs churn.
   task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input logic [1:0] exp_pop,
                          input int n_wait);
      arvalid = 1'b1;
      araddr  = addr;
      rready  = (n_wait == 0);
      check_eq("idle_arready", 32'(arready), 32'd0);
      step();
      check_eq("addr_arready", 32'(arready), 32'd1);
      check_eq("addr_rvalid", 32'(rvalid), 32'd0);
      step();
      arvalid = 1'b0;
      check_eq("data_arready", 32'(arready), 32'd0);
      check_eq("data_pop", 32'(rx_ready), 32'(exp_pop));
      step();
      check_eq("resp_rvalid", 32'(rvalid), 32'd1);
      check_eq("resp_rdata", rdata, exp_data);
      check_eq("resp_rresp", 32'(rresp), 32'(exp_resp));
      check_eq("resp_pop", 32'(rx_ready), 32'd0);
      for (int k = 1; k <= n_wait; k++) begin
         rx_data[1] = rx_data[1] ^ 32'h0F0F_0000;
         arvalid    = ~arvalid;
         step();
         check_eq("hold_rvalid", 32'(rvalid), 32'd1);
         check_eq("hold_rdata", rdata, exp_data);
         check_eq("hold_rresp", 32'(rresp), 32'(exp_resp));
         check_eq("hold_arready", 32'(arready), 32'd0);
         check_eq("hold_pop", 32'(rx_ready), 32'd0);
      end
      arvalid = 1'b0;
      rready  = 1'b1;
      step();
      check_eq("done_rvalid", 32'(rvalid), 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      araddr    = '0;
      arvalid   = 1'b0;
      rready    = 1'b1;
      rx_data   = '0;
      rx_v      = '0;
      rx_occ    = '0;
      clear_isr = '0;
      #1;
      check_eq("rst_arready", 32'(arready), 32'd0);
      check_eq("rst_rvalid", 32'(rvalid), 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_rresp", 32'(rresp), 32'd0);
      check_eq("rst_pop", 32'(rx_ready), 32'd0);
      check_eq("rst_isr", 32'(isr_rc), 32'd0);
      step();
      step();
      reset_n = 1'b1;
      step();

      // 1: pop FIFO1
      rx_data[1] = 32'hDEAD_BEEF;
      rx_v       = 2'b10;
      rx_occ[1]  = 16'd3;
      pop_base   = pop_cnt;
      do_read(32'h120, 32'hDEAD_BEEF, 2'b00, 2'b10, 0);
      check_eq("t1_pops", 32'(pop_cnt - pop_base), 32'd1);

      // 2: empty FIFO0 -> SLVERR
      do_read(32'h020, 32'h0, 2'b10, 2'b00, 0);

      // 3: occupancy, unmapped offset, missing index
      rx_occ[1] = 16'h0005;
      rx_occ[0] = 16'hABCD;
      do_read(32'h11C, 32'h0000_0005, 2'b00, 2'b00, 0);
      do_read(32'h01C, 32'h0000_ABCD, 2'b00, 2'b00, 0);
      do_read(32'h104, 32'h0, 2'b00, 2'b00, 0);
      do_read(32'h300, 32'h0, 2'b11, 2'b00, 0);

      // 4: sticky receive-complete
      rx_v[0] = 1'b1;
      step();
      check_eq("t4_isr_set", 32'(isr_rc), 32'd3);
      do_read(32'h000, 32'h0400_0000, 2'b00, 2'b00, 0);
      do_read(32'h000, 32'h0400_0000, 2'b00, 2'b00, 0);
      clear_isr = 2'b01;
      step();
      clear_isr = 2'b00;
      check_eq("t4_isr_clr", 32'(isr_rc), 32'd2);
      rx_v[0] = 1'b0;
      step();
      rx_v[0]   = 1'b1;
      clear_isr = 2'b11;
      step();
      clear_isr = 2'b00;
      check_eq("t4_set_wins", 32'(isr_rc), 32'd1);
      do_read(32'h100, 32'h0, 2'b00, 2'b00, 0);

      // 5: backpressured response
      rx_data[1] = 32'h1234_5678;
      pop_base   = pop_cnt;
      do_read(32'h120, 32'h1234_5678, 2'b00, 2'b10, 5);
      check_eq("t5_pops", 32'(pop_cnt - pop_base), 32'd1);

      // 6: asynchronous reset while in E_RD_DATA
      rx_data[1] = 32'hCAFE_F00D;
      pop_base   = pop_cnt;
      arvalid    = 1'b1;
      araddr     = 32'h120;
      step();
      step();
      arvalid = 1'b0;
      reset_n = 1'b0;
      #1;
      check_eq("t6_arready", 32'(arready), 32'd0);
      check_eq("t6_rvalid", 32'(rvalid), 32'd0);
      check_eq("t6_rdata", rdata, 32'd0);
      check_eq("t6_rresp", 32'(rresp), 32'd0);
      check_eq("t6_pop", 32'(rx_ready), 32'd0);
      check_eq("t6_isr", 32'(isr_rc), 32'd0);
      step();
      step();
      check_eq("t6_rvalid_held", 32'(rvalid), 32'd0);
      reset_n = 1'b1;
      step();
      check_eq("t6_no_pop", 32'(pop_cnt - pop_base), 32'd0);
      do_read(32'h120, 32'hCAFE_F00D, 2'b00, 2'b10, 0);
      check_eq("t6_one_pop", 32'(pop_cnt - pop_base), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
